matmul_mem_initiator: RTL and testbench
=======================================

// Module: matmul_mem_initiator
// PURPOSE
//   Bus initiator for the single-port data memory: on start, reads NxN matrices A and B
//   (row-major), computes C = A*B and writes C back into the same memory.
//   Drives the address/write_data/mem_read/mem_write side and consumes read_data.
//   Used as the hardware reference engine for the pipelined matrix-multiply program.
// PARAMETERS
//   N         3   matrix dimension (N >= 1)
//   A_BASE    0   word address of A[0][0]
//   B_BASE    9   word address of B[0][0]
//   C_BASE    18  word address of C[0][0]
//   READ_LAT  2   cycles from read issue to sampling read_data (>= 2)
// PORTS
//   clock       in   1   single clock, all state updates on posedge
//   reset       in   1   synchronous, active-high
//   start       in   1   request one multiply; sampled only in IDLE
//   busy        out  1   high from the cycle after start is accepted through the DONE cycle
//   done        out  1   one-cycle pulse when the last C word has been written
//   address     out  32  word address to memory
//   write_data  out  32  data to memory, valid while mem_write=1
//   mem_read    out  1   read strobe
//   mem_write   out  1   write strobe; memory commits on the low phase of the same cycle
//   read_data   in   32  memory read data, sampled only at the end of a WAIT state
// BEHAVIOUR
//   - Reset: busy=0, done=0, mem_read=0, mem_write=0, address=0, write_data=0, acc=0,
//     i=j=k=0, state=IDLE. Reset in any state aborts at once; no write is issued after it.
//   - All outputs are registered. mem_read and mem_write are never high together.
//   - FSM: IDLE -> RD_A -> WAIT_A -> RD_B -> WAIT_B -> MAC -> (k<N-1 ? RD_A : WR_C)
//          WR_C -> (last element ? DONE : RD_A) ; DONE -> IDLE.
//   - RD_A: address=A_BASE+i*N+k, mem_read=1 for 1 cycle. WAIT_A: address and mem_read held
//     for READ_LAT-1 cycles; read_data captured into a_reg at the last one. RD_B/WAIT_B
//     work the same way with address=B_BASE+k*N+j, capturing into b_reg.
//   - MAC (1 cycle, strobes low): acc += signed(a_reg)*signed(b_reg), 64-bit signed acc.
//   - WR_C (1 cycle): address=C_BASE+i*N+j, write_data=acc result (see CONFIGURATION),
//     mem_write=1; acc cleared; k=0; j++ with wrap to 0 and i++. Order is row-major.
//   - Cycle cost per element = N*(2*READ_LAT+1)+1. Defaults: 16 cycles, 144 in total.
//     start is sampled at edge 0. busy rises at edge 0 and done pulses in cycle 145.
//   - DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0. start is ignored
//     outside IDLE, including in the DONE cycle.
//   - read_data is ignored when not in a WAIT state. It may be X.
//   - Address sums are 32-bit unsigned. Overlap of the A/B/C regions is not checked.
//   - N=1: a single element is computed. The path is RD_A, WAIT_A, RD_B, WAIT_B, MAC,
//     WR_C, DONE.
// CONFIGURATION
//   MATMUL_SAT_EN defined: write_data = acc clamped to [0x80000000, 0x7FFFFFFF] (signed).
//   MATMUL_SAT_EN undefined: write_data = acc[31:0] (wrap-around). Timing is identical.
// TESTING
//   1 reset 3 cycles -> all outputs 0, state IDLE; start held low 20 cycles -> no strobes.
//   2 A=[6 2 3;5 5 4;5 6 5] @0, B=[7 2 2;5 2 5;3 5 8] @9, pulse start -> m[18..26]=
//     61 31 46 72 40 67 80 47 80; done one cycle, 145 cycles after start; busy low next.
//   3 start re-pulsed at cycles 10 and 145 of a run -> ignored; exactly 9 writes, 1 done.
//   4 reset asserted at cycle 50 -> only m[18..20] updated, m[21..26] unchanged,
//     mem_write=0 from the next cycle, busy=0, done never pulses.
//   5 A all 0x40000000, B all 4: without MATMUL_SAT_EN every C word = 0x00000000.
//     With it every C word = 0x7FFFFFFF. A all 0xC0000000 with it -> 0x80000000.
//   6 protocol monitor over all runs: never mem_read&&mem_write; address stays in
//     [A_BASE, C_BASE+N*N-1]; mem_write occurs exactly N*N times per start.

Source files
------------

// File: rtl/matmul_mem_initiator_if.sv
// ---------------------------------------------------------------------------
// matmul_mem_initiator_if
//   Single-port data memory bus between the matrix-multiply initiator and
//   the memory.
//   address     word address driven by the initiator
//   write_data  store data, valid while mem_write=1
//   mem_read    read strobe
//   mem_write   write strobe (memory commits on the low clock phase)
//   read_data   load data returned by the memory
// Modports: master = initiator side, slave = memory side.
// ---------------------------------------------------------------------------
interface matmul_mem_initiator_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_read;
    logic        mem_write;

    modport master (
        output address,
        output write_data,
        output mem_read,
        output mem_write,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  mem_read,
        input  mem_write,
        output read_data
    );
endinterface

// File: rtl/matmul_mem_initiator.sv
// ---------------------------------------------------------------------------
// matmul_mem_initiator
//   Bus initiator that reads two NxN row-major matrices A and B from the
//   single-port data memory, computes C = A*B with a 64-bit signed
//   accumulator and writes C back to memory in row-major order.
//
// Ports
//   clock     single clock, all state updates on posedge
//   reset     synchronous, active-high; aborts any run immediately
//   start     requests one multiply, sampled only in IDLE
//   busy      high from the cycle after start is accepted through DONE
//   done      one-cycle pulse after the last C word has been written
//   bus       memory bus (master modport): address, write_data,
//             mem_read, mem_write out; read_data in
//
// Build option
//   MATMUL_SAT_EN  when defined, each C word is the accumulator clamped to
//                  the signed 32-bit range; otherwise the low 32 bits are
//                  written (wrap-around). Timing is the same either way.
// ---------------------------------------------------------------------------
module matmul_mem_initiator #(
    parameter int N        = 3,
    parameter int A_BASE   = 0,
    parameter int B_BASE   = 9,
    parameter int C_BASE   = 18,
    parameter int READ_LAT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    matmul_mem_initiator_if.master bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int WC_W  = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [WC_W-1:0]  WC_INIT  = WC_W'(READ_LAT - 2);
    localparam logic [31:0]      N32      = 32'(N);
    localparam logic [31:0]      A_B32    = 32'(A_BASE);
    localparam logic [31:0]      B_B32    = 32'(B_BASE);
    localparam logic [31:0]      C_B32    = 32'(C_BASE);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        MAC,
        WR_C,
        DONE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    i;
    logic [IDX_W-1:0]    j;
    logic [IDX_W-1:0]    k;
    logic [WC_W-1:0]     wcnt;
    logic signed [31:0]  a_reg;
    logic signed [31:0]  b_reg;
    logic signed [63:0]  acc;
    logic signed [63:0]  a_ext;
    logic signed [63:0]  b_ext;
    logic signed [63:0]  prod;
    logic signed [63:0]  acc_next;

    // Row-major word address: base + row*N + col, 32-bit unsigned wrap.
    function automatic logic [31:0] addr_of(input logic [31:0]      base,
                                            input logic [IDX_W-1:0] row,
                                            input logic [IDX_W-1:0] col);
        return base + 32'(row) * N32 + 32'(col);
    endfunction

    // Reduce the 64-bit accumulator to the 32-bit C word.
    function automatic logic [31:0] fmt_c(input logic signed [63:0] v);
`ifdef MATMUL_SAT_EN
        logic signed [63:0] sat_max;
        logic signed [63:0] sat_min;
        sat_max = 64'sh0000_0000_7FFF_FFFF;
        sat_min = -64'sh0000_0000_8000_0000;
        if (v > sat_max)
            return 32'h7FFF_FFFF;
        else if (v < sat_min)
            return 32'h8000_0000;
        else
            return 32'(v);
`else
        return 32'(v);
`endif
    endfunction

    // Full 32x32 signed product, sign-extended operands keep the multiply exact.
    assign a_ext    = {{32{a_reg[31]}}, a_reg};
    assign b_ext    = {{32{b_reg[31]}}, b_reg};
    assign prod     = a_ext * b_ext;
    assign acc_next = acc + prod;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.address    <= 32'd0;
            bus.write_data <= 32'd0;
            acc            <= 64'sd0;
            i              <= '0;
            j              <= '0;
            k              <= '0;
            wcnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy         <= 1'b1;
                        i            <= '0;
                        j            <= '0;
                        k            <= '0;
                        acc          <= 64'sd0;
                        bus.address  <= addr_of(A_B32, '0, '0);
                        bus.mem_read <= 1'b1;
                        state        <= RD_A;
                    end
                end

                // Read issue cycles: address/mem_read were set on entry and
                // are simply held through the wait cycles that follow.
                RD_A: begin
                    wcnt  <= WC_INIT;
                    state <= WAIT_A;
                end

                WAIT_A: begin
                    if (wcnt == '0) begin
                        a_reg       <= bus.read_data;
                        bus.address <= addr_of(B_B32, k, j);
                        state       <= RD_B;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end

                RD_B: begin
                    wcnt  <= WC_INIT;
                    state <= WAIT_B;
                end

                WAIT_B: begin
                    if (wcnt == '0) begin
                        b_reg        <= bus.read_data;
                        bus.mem_read <= 1'b0;
                        state        <= MAC;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end

                // On the last k the result is formatted from acc_next so the
                // registered write_data is already valid during WR_C.
                MAC: begin
                    acc <= acc_next;
                    if (k != IDX_LAST) begin
                        k            <= k + 1'b1;
                        bus.address  <= addr_of(A_B32, i, k + 1'b1);
                        bus.mem_read <= 1'b1;
                        state        <= RD_A;
                    end else begin
                        bus.address    <= addr_of(C_B32, i, j);
                        bus.write_data <= fmt_c(acc_next);
                        bus.mem_write  <= 1'b1;
                        state          <= WR_C;
                    end
                end

                WR_C: begin
                    bus.mem_write <= 1'b0;
                    acc           <= 64'sd0;
                    k             <= '0;
                    if (j == IDX_LAST) begin
                        j <= '0;
                        if (i == IDX_LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            i            <= i + 1'b1;
                            bus.address  <= addr_of(A_B32, i + 1'b1, '0);
                            bus.mem_read <= 1'b1;
                            state        <= RD_A;
                        end
                    end else begin
                        j            <= j + 1'b1;
                        bus.address  <= addr_of(A_B32, i, '0);
                        bus.mem_read <= 1'b1;
                        state        <= RD_A;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_matmul_mem_initiator
//   Bench for matmul_mem_initiator with a behavioural single-port memory,
//   a scoreboard of expected C writes and a bus protocol monitor.
// ---------------------------------------------------------------------------
module tb_matmul_mem_initiator;

    localparam int N        = 3;
    localparam int A_BASE   = 0;
    localparam int B_BASE   = 9;
    localparam int C_BASE   = 18;
    localparam int READ_LAT = 2;
    localparam int RUN_CYC  = N * N * (N * (2 * READ_LAT + 1) + 1);
    localparam int TIMEOUT  = 2000;

    logic clk;
    logic reset;
    logic start;
    logic busy;
    logic done;

    matmul_mem_initiator_if bus ();

    matmul_mem_initiator #(
        .N        (N),
        .A_BASE   (A_BASE),
        .B_BASE   (B_BASE),
        .C_BASE   (C_BASE),
        .READ_LAT (READ_LAT)
    ) dut (
        .clock (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    logic [31:0] mem [64];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          total;
    int          bad;
    int          wr_cnt;
    int          rd_cnt;
    int          done_cnt;
    int unsigned addr_lo;
    int unsigned addr_hi;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory read path: data registered one edge after the read is seen,
    // unknown whenever no read is in progress.
    always @(posedge clk) begin
        if (bus.mem_read)
            bus.read_data <= mem[bus.address[5:0]];
        else
            bus.read_data <= 'x;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor and memory write port (commits on the low phase).
    initial begin
        logic [31:0] ea;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (done === 1'b1)
                    done_cnt++;
                if (bus.mem_read || bus.mem_write) begin
                    chk("rw_exclusive", {63'd0, bus.mem_read & bus.mem_write}, 64'd0);
                    chk("addr_range", {63'd0, (bus.address >= addr_lo) && (bus.address <= addr_hi)}, 64'd1);
                    if (bus.mem_read)
                        rd_cnt++;
                end
                if (bus.mem_write) begin
                    wr_cnt++;
                    mem[bus.address[5:0]] = bus.write_data;
                    if (exp_addr.size() == 0) begin
                        chk("sb_extra_write", 64'(exp_addr.size()), 64'd1);
                    end else begin
                        ea = exp_addr.pop_front();
                        ed = exp_data.pop_front();
                        chk("c_addr", 64'(bus.address), 64'(ea));
                        chk("c_data", 64'(bus.write_data), 64'(ed));
                    end
                end
            end
        end
    end

    // Reference: plain sum of signed products over memory contents.
    function automatic logic [31:0] model_c(input int r, input int c);
        longint s;
        longint x;
        longint y;
        s = 0;
        for (int kk = 0; kk < N; kk++) begin
            x = longint'($signed(mem[A_BASE + r * N + kk]));
            y = longint'($signed(mem[B_BASE + kk * N + c]));
            s = s + x * y;
        end
`ifdef MATMUL_SAT_EN
        if (s > 64'sh7FFF_FFFF)
            return 32'h7FFF_FFFF;
        else if (s < -64'sh8000_0000)
            return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic push_expected(input int count);
        for (int e = 0; e < count; e++) begin
            exp_addr.push_back(32'(C_BASE + e));
            exp_data.push_back(model_c(e / N, e % N));
        end
    endtask

    task automatic load_fill(input logic [31:0] av, input logic [31:0] bv);
        for (int e = 0; e < N * N; e++) begin
            mem[A_BASE + e] = av;
            mem[B_BASE + e] = bv;
        end
    endtask

    task automatic run(input bit poke);
        int cyc;
        int wr0;
        int dn0;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", {63'd0, busy}, 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
            if (poke)
                start = (cyc == 10);
        end
        chk("done_latency", 64'(cyc), 64'(RUN_CYC));
        chk("done_high", {63'd0, done}, 64'd1);
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        if (poke)
            start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("busy_fall", {63'd0, busy}, 64'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("write_count", 64'(wr_cnt - wr0), 64'(N * N));
        chk("done_count", 64'(done_cnt - dn0), 64'd1);
        chk("sb_empty", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] a_init [9];
        logic [31:0] b_init [9];
        logic [31:0] c_ref  [9];
        logic [31:0] sat_pos;
        logic [31:0] sat_neg;
        int          wr0;
        int          rd0;
        int          dn0;

        a_init = '{32'd6, 32'd2, 32'd3, 32'd5, 32'd5, 32'd4, 32'd5, 32'd6, 32'd5};
        b_init = '{32'd7, 32'd2, 32'd2, 32'd5, 32'd2, 32'd5, 32'd3, 32'd5, 32'd8};
        c_ref  = '{32'd61, 32'd31, 32'd46, 32'd72, 32'd40, 32'd67, 32'd80, 32'd47, 32'd80};
`ifdef MATMUL_SAT_EN
        sat_pos = 32'h7FFF_FFFF;
        sat_neg = 32'h8000_0000;
`else
        sat_pos = 32'h0000_0000;
        sat_neg = 32'h0000_0000;
`endif
        total    = 0;
        bad      = 0;
        wr_cnt   = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        addr_lo  = A_BASE;
        addr_hi  = C_BASE + N * N - 1;
        for (int e = 0; e < 64; e++)
            mem[e] = 32'd0;
        reset = 1'b1;
        start = 1'b0;

        // 1: reset state and idle with start low
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_mem_read", {63'd0, bus.mem_read}, 64'd0);
        chk("rst_mem_write", {63'd0, bus.mem_write}, 64'd0);
        chk("rst_address", 64'(bus.address), 64'd0);
        chk("rst_write_data", 64'(bus.write_data), 64'd0);
        reset = 1'b0;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_reads", 64'(rd_cnt - rd0), 64'd0);
        chk("idle_no_writes", 64'(wr_cnt - wr0), 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // 2: directed 3x3 multiply
        for (int e = 0; e < 9; e++) begin
            mem[A_BASE + e] = a_init[e];
            mem[B_BASE + e] = b_init[e];
        end
        push_expected(N * N);
        run(1'b0);
        for (int e = 0; e < 9; e++)
            chk($sformatf("c_mem_%0d", e), 64'(mem[C_BASE + e]), 64'(c_ref[e]));

        // 3: start re-pulsed mid-run and in the DONE cycle
        for (int e = 0; e < 9; e++)
            mem[C_BASE + e] = 32'hFFFF_FFFF;
        push_expected(N * N);
        run(1'b1);
        for (int e = 0; e < 9; e++)
            chk($sformatf("c_rerun_%0d", e), 64'(mem[C_BASE + e]), 64'(c_ref[e]));

        // 4: reset at cycle 50 aborts after three writes
        for (int e = 0; e < 9; e++)
            mem[C_BASE + e] = 32'hDEAD_0000 + 32'(e);
        push_expected(3);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_write", {63'd0, bus.mem_write}, 64'd0);
        chk("abort_mem_read", {63'd0, bus.mem_read}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("abort_writes", 64'(wr_cnt - wr0), 64'd3);
        chk("abort_no_done", 64'(done_cnt - dn0), 64'd0);
        chk("abort_sb_empty", 64'(exp_addr.size()), 64'd0);
        for (int e = 0; e < 3; e++)
            chk($sformatf("abort_c_%0d", e), 64'(mem[C_BASE + e]), 64'(c_ref[e]));
        for (int e = 3; e < 9; e++)
            chk($sformatf("abort_keep_%0d", e), 64'(mem[C_BASE + e]), 64'(32'hDEAD_0000 + 32'(e)));

        // 5: accumulator overflow beyond 32 bits
        load_fill(32'h4000_0000, 32'd4);
        push_expected(N * N);
        run(1'b0);
        for (int e = 0; e < 9; e++)
            chk($sformatf("ovf_pos_%0d", e), 64'(mem[C_BASE + e]), 64'(sat_pos));
        load_fill(32'hC000_0000, 32'd4);
        push_expected(N * N);
        run(1'b0);
        for (int e = 0; e < 9; e++)
            chk($sformatf("ovf_neg_%0d", e), 64'(mem[C_BASE + e]), 64'(sat_neg));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
